// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard sources in, per-stage stall/flush controls and perf counts out.
interface pipe_hazard_ctrl_if;
    logic        icache_stall;
    logic        dcache_stall;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_branch_taken;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_mdu_start;
    logic        pc_stall;
    logic        fd_stall;
    logic        fd_flush;
    logic        de_stall;
    logic        de_flush;
    logic        em_stall;
    logic        em_flush;
    logic        mw_stall;
    logic        mdu_busy;
    logic        mdu_done;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    modport master (
        output icache_stall, dcache_stall, id_rs, id_rt, id_uses_rt, id_branch_taken,
               ex_mem_read, ex_rt, ex_mdu_start,
        input  pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush,
               mw_stall, mdu_busy, mdu_done, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  icache_stall, dcache_stall, id_rs, id_rt, id_uses_rt, id_branch_taken,
               ex_mem_read, ex_rt, ex_mdu_start,
        output pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush,
               mw_stall, mdu_busy, mdu_done, perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline sequencer (cache stall > MDU > load-use > branch flush).
// Define HAZ_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int MDU_CYCLES = 4,
    parameter int CNT_W      = 4
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [0:0]       RUN      = 1'b0;
    localparam logic [0:0]       MDU_BUSY = 1'b1;
    localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_CYCLES >= 2 ? MDU_CYCLES - 2 : 0);

    logic [0:0]       state;
    logic [CNT_W-1:0] mdu_cnt;
    logic             cache, mdu_start, mdu_hold, mdu_fin, load_use, front_stall, br_flush;

    always_comb begin
        cache       = bus.icache_stall | bus.dcache_stall;
        mdu_start   = state == RUN && bus.ex_mdu_start;
        mdu_hold    = !cache && ((mdu_start && MDU_CYCLES >= 2) || (state == MDU_BUSY && mdu_cnt != '0));
        mdu_fin     = !cache && ((mdu_start && MDU_CYCLES == 1) || (state == MDU_BUSY && mdu_cnt == '0));
        load_use    = !cache && state == RUN && !bus.ex_mdu_start && bus.ex_mem_read && bus.ex_rt != 5'd0 &&
                      (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
        front_stall = cache | mdu_hold | load_use;
        br_flush    = bus.id_branch_taken && !front_stall;
    end

    // Every control is masked while reset is held, independent of the state flops.
    assign bus.pc_stall = !rst && front_stall;
    assign bus.fd_stall = !rst && front_stall;
    assign bus.fd_flush = !rst && br_flush;
    assign bus.de_stall = !rst && (cache | mdu_hold);
    assign bus.de_flush = !rst && load_use;
    assign bus.em_stall = !rst && cache;
    assign bus.em_flush = !rst && mdu_hold;
    assign bus.mw_stall = !rst && cache;
    assign bus.mdu_busy = !rst && state == MDU_BUSY;
    assign bus.mdu_done = !rst && mdu_fin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            mdu_cnt <= '0;
        end else if (!cache) begin
            if (mdu_start && MDU_CYCLES >= 2) begin
                state   <= MDU_BUSY;
                mdu_cnt <= MDU_LOAD;
            end else if (state == MDU_BUSY) begin
                state   <= mdu_cnt != '0 ? MDU_BUSY : RUN;
                mdu_cnt <= mdu_cnt != '0 ? mdu_cnt - CNT_W'(1) : mdu_cnt;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 32'(front_stall);
            flush_cnt <= flush_cnt + 32'(br_flush);
        end
    end

    assign bus.perf_stall_cnt = stall_cnt;
    assign bus.perf_flush_cnt = flush_cnt;
`else
    assign bus.perf_stall_cnt = 32'h0;
    assign bus.perf_flush_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl (MDU_CYCLES=4).
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    pipe_hazard_ctrl_if bus();
    pipe_hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // {pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_stall, mdu_busy, mdu_done}
    localparam logic [9:0] IDLE = 10'b0000000000;
    localparam logic [9:0] LU   = 10'b1100100000;
    localparam logic [9:0] SM   = 10'b1101001000;
    localparam logic [9:0] C    = 10'b1101010100;
    localparam logic [9:0] FDF  = 10'b0010000000;
    localparam logic [9:0] BUSY = 10'b0000000010;
    localparam logic [9:0] DONE = 10'b0000000001;

    logic [9:0] exp_q[$];
    string      tag_q[$];
    logic [9:0] obs;

    assign obs = {bus.pc_stall, bus.fd_stall, bus.fd_flush, bus.de_stall, bus.de_flush,
                  bus.em_stall, bus.em_flush, bus.mw_stall, bus.mdu_busy, bus.mdu_done};

    task automatic check_out();
        logic [9:0] e;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", t, obs, e);
        end
    endtask

    task automatic drive(input logic ic, input logic dc, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt, input logic br, input logic mr, input logic [4:0] ert,
                         input logic ms, input logic [9:0] e, input string t);
        bus.icache_stall    = ic;
        bus.dcache_stall    = dc;
        bus.id_rs           = rs;
        bus.id_rt           = rt;
        bus.id_uses_rt      = urt;
        bus.id_branch_taken = br;
        bus.ex_mem_read     = mr;
        bus.ex_rt           = ert;
        bus.ex_mdu_start    = ms;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic check_perf(input string t, input logic [31:0] s, input logic [31:0] f);
`ifdef HAZ_PERF_CNT_EN
        logic [31:0] es = s;
        logic [31:0] ef = f;
`else
        logic [31:0] es = 32'h0;
        logic [31:0] ef = 32'h0;
`endif
        checks += 2;
        assert (bus.perf_stall_cnt === es) else begin
            failures++;
            $error("FAIL %s_stall observed=%0d expected=%0d", t, bus.perf_stall_cnt, es);
        end
        assert (bus.perf_flush_cnt === ef) else begin
            failures++;
            $error("FAIL %s_flush observed=%0d expected=%0d", t, bus.perf_flush_cnt, ef);
        end
    endtask

    initial begin
        drive(0, 1, 5, 0, 0, 1, 1, 5, 1, IDLE, "reset_forces_zero");
        check_perf("perf_reset", 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, "post_reset_idle");
        drive(0, 0, 5, 0, 0, 0, 1, 5, 0, LU,   "lu_rs");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, "lu_release");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, IDLE, "lu_r0");
        drive(0, 0, 3, 7, 1, 0, 1, 7, 0, LU,   "lu_rt");
        drive(0, 0, 3, 7, 0, 0, 1, 7, 0, IDLE, "lu_rt_unused");
        drive(1, 0, 5, 0, 0, 0, 1, 5, 0, C,    "icache_stall");
        // Reset in the middle of an MDU operation
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, SM,   "rst_mdu_start");
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, "rst_mid_mdu");
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, "rst_mdu_no_done");
        check_perf("perf_after_rst", 0, 0);
        // MDU with start held through busy (ignored), then one branch flush
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, SM,          "mdu_c0");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, SM | BUSY,   "mdu_c1");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, SM | BUSY,   "mdu_c2");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, BUSY | DONE, "mdu_c3");
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, FDF,         "branch_flush");
        check_perf("perf_mdu_branch", 3, 1);
        // MDU start wins over a simultaneous load-use
        drive(0, 0, 5, 0, 0, 0, 1, 5, 1, SM,          "mdu_beats_lu");
        drive(0, 0, 5, 0, 0, 0, 1, 5, 0, SM | BUSY,   "mdu_lu_c1");
        drive(0, 0, 5, 0, 0, 0, 1, 5, 0, SM | BUSY,   "mdu_lu_c2");
        drive(0, 0, 5, 0, 0, 0, 1, 5, 0, BUSY | DONE, "mdu_lu_done");
        drive(0, 0, 5, 0, 0, 0, 1, 5, 0, LU,          "lu_after_done");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE,        "idle_a");
        // D-cache miss while mdu_cnt=1 delays mdu_done by three cycles
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, SM,          "mdu_cs_c0");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, SM | BUSY,   "mdu_cs_c1");
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, C | BUSY,    "mdu_cs_stall0");
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, C | BUSY,    "mdu_cs_stall1");
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, C | BUSY,    "mdu_cs_stall2");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, SM | BUSY,   "mdu_cs_resume");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, BUSY | DONE, "mdu_cs_done");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE,        "idle_b");
        // Branch held by load-use, then released; branch under cache stall
        drive(0, 0, 5, 0, 0, 1, 1, 5, 0, LU,          "br_lu");
        drive(0, 0, 5, 0, 0, 1, 0, 5, 0, FDF,         "br_after_lu");
        drive(0, 1, 0, 0, 0, 1, 0, 0, 0, C,           "br_cache");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE,        "idle_c");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Drives stall and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB from four sources: cache-miss stalls, the multi-cycle mult/div unit (MDU), load-use hazards, and taken branches/jumps.
- Its fd_stall/fd_flush outputs feed the IF/ID register's stall (FDWrite) and nop inputs directly.

Parameters:
- MDU_CYCLES, 4, EX-stage occupancy in cycles of a mult/div instruction; legal range 1..15.
- CNT_W, 4, width of the internal MDU countdown register.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- icache_stall  input  1  I-cache miss in progress.
- dcache_stall  input  1  D-cache (or L2) miss in progress.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt as a source.
- id_branch_taken  input  1  branch/jump resolved taken in ID.
- ex_mem_read  input  1  EX-stage instruction is a load.
- ex_rt  input  5  destination of the EX-stage load.
- ex_mdu_start  input  1  EX-stage instruction is mult/div.
- pc_stall  output  1  hold PC.
- fd_stall  output  1  hold IF/ID.
- fd_flush  output  1  zero the IF/ID instruction.
- de_stall  output  1  hold ID/EX.
- de_flush  output  1  insert bubble into ID/EX.
- em_stall  output  1  hold EX/MEM.
- em_flush  output  1  insert bubble into EX/MEM.
- mw_stall  output  1  hold MEM/WB.
- mdu_busy  output  1  FSM in MDU_BUSY.
- mdu_done  output  1  one-cycle pulse: MDU result valid this cycle.
- perf_stall_cnt  output  32  stall-cycle count (optional feature).
- perf_flush_cnt  output  32  branch-flush count (optional feature).

Behaviour:
- Registered state: FSM state (RUN, MDU_BUSY) and mdu_cnt[CNT_W-1:0]. All outputs are combinational from state and inputs, so they take effect in the same cycle.
- Reset (rst=1, asynchronous): state=RUN, mdu_cnt=0, perf counters=0. While rst=1, all outputs are forced to 0.
- Priority: cache stall > MDU > load-use > branch flush.
- Cache stall (icache_stall|dcache_stall):
  - Assert pc_stall, fd_stall, de_stall, em_stall, mw_stall.
  - All flush outputs and mdu_done are 0.
  - State and mdu_cnt are frozen.
  - Applies in both states.
- RUN, ex_mdu_start=1, MDU_CYCLES>=2:
  - Assert pc_stall, fd_stall, de_stall, em_flush.
  - mdu_cnt<=MDU_CYCLES-2; next state MDU_BUSY.
- RUN, ex_mdu_start=1, MDU_CYCLES=1: mdu_done=1, no stall.
- MDU_BUSY, mdu_cnt!=0: assert pc_stall, fd_stall, de_stall, em_flush; mdu_cnt decrements.
- MDU_BUSY, mdu_cnt==0:
  - mdu_done=1; no stall or flush from MDU.
  - Next state RUN.
  - ex_mdu_start is ignored throughout MDU_BUSY.
  - Total EX occupancy is exactly MDU_CYCLES non-cache-stall cycles.
- Load-use (RUN, no MDU start): ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
  - Assert pc_stall, fd_stall, de_flush. One bubble.
  - Re-evaluated every cycle.
- Branch flush: fd_flush = id_branch_taken && !fd_stall.
  - fd_flush and fd_stall are never both 1.
  - A branch held in ID by a stall is re-evaluated when the stall releases.
- A flush and a stall on the same stage are never both asserted.
- Simultaneous ex_mdu_start and load-use: MDU wins; load-use is re-detected after mdu_done.
- Reset mid-MDU: returns to RUN immediately; no mdu_done pulse.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - perf_stall_cnt increments on every cycle with pc_stall=1.
  - perf_flush_cnt increments on every cycle with fd_flush=1.
  - Both wrap at 2^32 and clear on rst.
- HAZ_PERF_CNT_EN undefined: both ports are tied to 32'h0 and no counter flops exist.

Test Plan:
- Reset: rst pulse mid-operation -> all outputs 0 and state RUN asynchronously; after release with idle inputs, outputs stay 0.
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for 1 cycle -> pc_stall=fd_stall=de_flush=1 that cycle only. Same with ex_rt=0 -> no stall.
- MDU, MDU_CYCLES=4: ex_mdu_start at cycle 0 -> stalls + em_flush in cycles 0-2; mdu_done=1 and no stall in cycle 3; mdu_busy=1 in cycles 1-3.
- Cache stall mid-MDU: dcache_stall=1 for 3 cycles during MDU_BUSY with mdu_cnt=1 -> all five stalls asserted, em_flush=0, mdu_cnt frozen; mdu_done lands 3 cycles later than without the stall.
- Branch flush: id_branch_taken=1 with no hazard -> fd_flush=1. With simultaneous load-use -> fd_flush=0, fd_stall=1; next cycle fd_flush=1.
- Perf counters (HAZ_PERF_CNT_EN): the MDU scenario followed by one branch flush -> perf_stall_cnt=3, perf_flush_cnt=1.
